// File: rtl/spi_note_sender.sv
// SPI master that serialises one frame of NUM_TRACKS note packets onto chipSelect/sck/sdi.
// sdi changes only on sck falling edges; the final SCK_LO phase doubles as chipSelect hold time.
module spi_note_sender #(
    parameter int unsigned NUM_TRACKS  = 4,
    parameter int unsigned PACKET_SIZE = 24,
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned CS_GAP      = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              valid,
    input  logic [NUM_TRACKS*PACKET_SIZE-1:0] notePackets,
    output logic                              ready,
    output logic                              done,
    output logic                              chipSelect,
    output logic                              sck,
    output logic                              sdi
);
    localparam int unsigned TOTAL = NUM_TRACKS * PACKET_SIZE;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);
    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_TOTAL = CNT_W'(TOTAL);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SCK_HI,
        SCK_LO,
        GAP
    } state_t;

    state_t           state_q, state_d;
    logic [TOTAL-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             cs_q, cs_d;
    logic             sck_q, sck_d;
    logic             sdi_q, sdi_d;
    logic             done_q, done_d;
    logic             ready_q, ready_d;
    logic             div_end;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        gap_d     = gap_q;
        cs_d      = cs_q;
        sck_d     = sck_q;
        sdi_d     = sdi_q;
        done_d    = 1'b0;
        div_end   = (div_q == DIV_LAST);

        case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d   = SETUP;
                    shreg_d   = notePackets;
                    bit_cnt_d = '0;
                    div_d     = '0;
                    cs_d      = 1'b1;
                    sck_d     = 1'b0;
                    sdi_d     = notePackets[TOTAL-1];
                end
            end
            SETUP: begin
                if (div_end) begin
                    div_d   = '0;
                    state_d = SCK_HI;
                    sck_d   = 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SCK_HI: begin
                if (div_end) begin
                    div_d     = '0;
                    state_d   = SCK_LO;
                    sck_d     = 1'b0;
                    shreg_d   = shreg_q << 1;
                    sdi_d     = shreg_d[TOTAL-1];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SCK_LO: begin
                if (div_end) begin
                    div_d = '0;
                    if (bit_cnt_q < CNT_TOTAL) begin
                        state_d = SCK_HI;
                        sck_d   = 1'b1;
                    end else begin
                        state_d = GAP;
                        cs_d    = 1'b0;
                        sdi_d   = 1'b0;
                        done_d  = 1'b1;
                        gap_d   = '0;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b0;
                sck_d   = 1'b0;
                sdi_d   = 1'b0;
            end
        endcase

        // ready is registered from the next state so it is high exactly while IDLE
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            gap_q     <= '0;
            cs_q      <= 1'b0;
            sck_q     <= 1'b0;
            sdi_q     <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            gap_q     <= gap_d;
            cs_q      <= cs_d;
            sck_q     <= sck_d;
            sdi_q     <= sdi_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign ready      = ready_q;
    assign done       = done_q;
    assign chipSelect = cs_q;
    assign sck        = sck_q;
    assign sdi        = sdi_q;
endmodule

// File: tb/tb_spi_note_sender.sv
// Directed bench for spi_note_sender: two instances (CLK_DIV=2 and CLK_DIV=1) observed through
// a per-cycle monitor that rebuilds the frame the way the tone-generator receiver would.
module tb_spi_note_sender;
    localparam int unsigned NT  = 4;
    localparam int unsigned PS  = 24;
    localparam int unsigned TOT = NT * PS;

    localparam logic [TOT-1:0] F1 = 96'h123480_ABCDFF_000000_0FFF40;
    localparam logic [TOT-1:0] F2 = 96'h800001_7FFFFE_AAAAAA_555555;
    localparam logic [TOT-1:0] F3 = 96'h13579B_2468AC_F0F0F0_0000FF;
    localparam logic [TOT-1:0] F4 = 96'hFEDCBA_987654_321000_A5A5A5;

    logic           clk = 1'b0;
    logic           reset;
    logic           valid;
    logic [TOT-1:0] note_packets;
    logic           ready_a, done_a, cs_a, sck_a, sdi_a;
    logic           ready_b, done_b, cs_b, sck_b, sdi_b;

    always #5 clk = ~clk;

    spi_note_sender #(.NUM_TRACKS(NT), .PACKET_SIZE(PS), .CLK_DIV(2), .CS_GAP(4)) u_dut_div2 (
        .clk(clk), .reset(reset), .valid(valid), .notePackets(note_packets),
        .ready(ready_a), .done(done_a), .chipSelect(cs_a), .sck(sck_a), .sdi(sdi_a)
    );

    spi_note_sender #(.NUM_TRACKS(NT), .PACKET_SIZE(PS), .CLK_DIV(1), .CS_GAP(4)) u_dut_div1 (
        .clk(clk), .reset(reset), .valid(valid), .notePackets(note_packets),
        .ready(ready_b), .done(done_b), .chipSelect(cs_b), .sck(sck_b), .sdi(sdi_b)
    );

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // monitor state, sampled once per cycle on the falling clock edge
    logic           sel = 1'b0;
    logic           cs_s = 1'b0, sck_s = 1'b0, sdi_s = 1'b0, done_s = 1'b0, ready_s = 1'b0;
    logic           cs_p = 1'b0, sck_p = 1'b0, sdi_p = 1'b0;
    logic [TOT-1:0] rx = '0, rx_frame = '0;
    logic           have_fall = 1'b0;
    int cyc = 0, acc_cnt = 0, acc_prev = 0, acc_last = 0, cs_hi = 0, rises = 0, frame_rises = 0;
    int first_off = 0, sdi_bad = 0, sck_bad = 0, done_cnt = 0, done_bad = 0, rx_valid = 0;
    int ready_bad = 0, busy = 0, cs_fall_cyc = 0, cs_rise_cyc = 0, min_low = 1000;

    task automatic tick();
        logic acc;
        acc = valid && ready_s && !reset;
        @(negedge clk);
        cyc++;
        cs_s    = sel ? cs_b    : cs_a;
        sck_s   = sel ? sck_b   : sck_a;
        sdi_s   = sel ? sdi_b   : sdi_a;
        done_s  = sel ? done_b  : done_a;
        ready_s = sel ? ready_b : ready_a;
        if (acc) begin
            acc_cnt++;
            acc_prev = acc_last;
            acc_last = cyc;
        end
        if (cs_s || sck_s || sdi_s || done_s || !ready_s) busy++;
        if (cs_s) cs_hi++;
        if (cs_s && ready_s) ready_bad++;
        if (sck_s && !cs_s) sck_bad++;
        if (cs_s && !cs_p) begin
            cs_rise_cyc = cyc;
            frame_rises = 0;
            if (have_fall && (cyc - cs_fall_cyc) < min_low) min_low = cyc - cs_fall_cyc;
        end
        if (sck_s && !sck_p) begin
            rises++;
            frame_rises++;
            if (frame_rises == 1) first_off = cyc - cs_rise_cyc;
            if (sdi_s != sdi_p) sdi_bad++;
            rx = {rx[TOT-2:0], sdi_s};
        end
        if (!cs_s && cs_p) begin
            have_fall   = 1'b1;
            cs_fall_cyc = cyc;
            if (frame_rises == TOT) begin
                rx_valid++;
                rx_frame = rx;
            end
        end
        if (done_s) begin
            done_cnt++;
            if (!(cs_p && !cs_s)) done_bad++;
        end
        cs_p  = cs_s;
        sck_p = sck_s;
        sdi_p = sdi_s;
    endtask

    task automatic clear_stats();
        acc_cnt = 0; acc_prev = 0; acc_last = 0; cs_hi = 0; rises = 0; frame_rises = 0;
        first_off = 0; sdi_bad = 0; sck_bad = 0; done_cnt = 0; done_bad = 0; rx_valid = 0;
        ready_bad = 0; busy = 0; min_low = 1000; have_fall = 1'b0; rx = '0; rx_frame = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt < target) chk("done_timeout", 96'(done_cnt), 96'(target));
        repeat (6) tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset        = 1'b1;
        valid        = 1'b0;
        note_packets = '0;
        sel          = 1'b0;

        // reset state, observed while reset is still held
        repeat (3) tick();
        chk("rst_ready", 96'(ready_s), 96'(1));
        chk("rst_cs",    96'(cs_s),    96'(0));
        chk("rst_sck",   96'(sck_s),   96'(0));
        chk("rst_sdi",   96'(sdi_s),   96'(0));
        chk("rst_done",  96'(done_s),  96'(0));
        reset = 1'b0;
        tick();

        // idle: nothing moves without valid
        clear_stats();
        repeat (1000) tick();
        chk("idle_busy", 96'(busy),    96'(0));
        chk("idle_acc",  96'(acc_cnt), 96'(0));

        // loopback, CLK_DIV=2
        clear_stats();
        note_packets = F1;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_done(1, 1000);
        chk("lb_frame",     rx_frame,           F1);
        chk("lb_cs_high",   96'(cs_hi),         96'(386));
        chk("lb_rises",     96'(rises),         96'(96));
        chk("lb_done",      96'(done_cnt),      96'(1));
        chk("lb_done_edge", 96'(done_bad),      96'(0));
        chk("lb_rx_valid",  96'(rx_valid),      96'(1));
        chk("lb_first_off", 96'(first_off),     96'(2));
        chk("lb_sdi_edge",  96'(sdi_bad),       96'(0));
        chk("lb_sck_no_cs", 96'(sck_bad),       96'(0));
        chk("lb_ready",     96'(ready_bad),     96'(0));
        chk("lb_idle_rdy",  96'(ready_s),       96'(1));

        // data change while a frame is in flight, plus a valid pulse that must be ignored
        clear_stats();
        note_packets = F3;
        valid = 1'b1;
        tick();
        note_packets = '1;
        valid = 1'b0;
        repeat (10) tick();
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_done(1, 1000);
        repeat (5) tick();
        chk("chg_frame", rx_frame,      F3);
        chk("chg_acc",   96'(acc_cnt),  96'(1));
        chk("chg_done",  96'(done_cnt), 96'(1));
        chk("chg_rxv",   96'(rx_valid), 96'(1));

        // reset after the 40th sck rising edge, then a full frame
        clear_stats();
        note_packets = F4;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        n = 0;
        while (rises < 40 && n < 500) begin
            tick();
            n++;
        end
        chk("mid_reach40", 96'(rises), 96'(40));
        reset = 1'b1;
        tick();
        chk("mid_cs",    96'(cs_s),    96'(0));
        chk("mid_sck",   96'(sck_s),   96'(0));
        chk("mid_sdi",   96'(sdi_s),   96'(0));
        chk("mid_ready", 96'(ready_s), 96'(1));
        reset = 1'b0;
        repeat (10) tick();
        chk("mid_no_done", 96'(done_cnt), 96'(0));
        chk("mid_no_rxv",  96'(rx_valid), 96'(0));
        valid = 1'b1;
        tick();
        valid = 1'b0;
        wait_done(1, 1000);
        chk("mid_rxv",   96'(rx_valid), 96'(1));
        chk("mid_frame", rx_frame,      F4);
        chk("mid_rises", 96'(rises),    96'(136));

        // back-to-back with valid held, CLK_DIV=1
        sel = 1'b1;
        do_reset();
        clear_stats();
        note_packets = F2;
        valid = 1'b1;
        n = 0;
        while (acc_cnt < 2 && n < 600) begin
            tick();
            n++;
        end
        valid = 1'b0;
        chk("b2b_acc", 96'(acc_cnt), 96'(2));
        wait_done(2, 1000);
        chk("b2b_spacing",   96'(acc_last - acc_prev), 96'(198));
        chk("b2b_cs_low",    96'(min_low),   96'(5));
        chk("b2b_ready",     96'(ready_bad), 96'(0));
        chk("b2b_rises",     96'(rises),     96'(192));
        chk("b2b_cs_high",   96'(cs_hi),     96'(386));
        chk("b2b_frame",     rx_frame,       F2);
        chk("b2b_rxv",       96'(rx_valid),  96'(2));
        chk("b2b_first_off", 96'(first_off), 96'(1));
        chk("b2b_sdi_edge",  96'(sdi_bad),   96'(0));
        chk("b2b_sck_no_cs", 96'(sck_bad),   96'(0));
        chk("b2b_done",      96'(done_cnt),  96'(2));
        chk("b2b_done_edge", 96'(done_bad),  96'(0));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
